// File: rtl/bsg_cgol_ctrl_gen.sv
// bsg_cgol_ctrl_gen
//   Next-generation controller for the Game-of-Life cell array. Accepts a job
//   (frames, snapshot interval) on a valid/ready channel, loads the board,
//   steps it frames_i generations, optionally presents intermediate snapshots,
//   and presents the final board on a yumi-style output channel.
//
//   Optional build macro: BSG_CGOL_CTRL_EARLY_EXIT_EN
//     defined   -> stable_i ends a job early and early_o can assert
//     undefined -> stable_i ignored, every job runs the full frames_i
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   en_i                   global enable; 0 freezes state and blocks handshakes
//   frames_i               generations to run for the job
//   snap_interval_i        generations between snapshots (0 = none)
//   v_i / ready_o          job handshake
//   stable_i               array reports board unchanged since last generation
//   yumi_i / v_o           output handshake (consumer takes board)
//   last_o                 1 = final result, 0 = intermediate snapshot
//   early_o                final result caused by stable_i
//   gen_o                  generations completed in the current job
//   update_o               array loads the input board this cycle
//   en_o                   array register enable (load or step)

module bsg_cgol_ctrl_gen #(
    parameter  int max_game_length_p = 1024,
    localparam int game_len_width_lp =
        ((max_game_length_p + 1) > 1) ? $clog2(max_game_length_p + 1) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    input  logic [game_len_width_lp-1:0] frames_i,
    input  logic [game_len_width_lp-1:0] snap_interval_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic                         stable_i,
    input  logic                         yumi_i,
    output logic                         v_o,
    output logic                         last_o,
    output logic                         early_o,
    output logic [game_len_width_lp-1:0] gen_o,
    output logic                         update_o,
    output logic                         en_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SNAP = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                       state_q,    state_d;
    logic [game_len_width_lp-1:0] gen_q,      gen_d;
    logic [game_len_width_lp-1:0] snap_q,     snap_d;
    logic [game_len_width_lp-1:0] target_q,   target_d;
    logic [game_len_width_lp-1:0] interval_q, interval_d;
    logic                         early_q,    early_d;

    logic                         halt;
    logic [game_len_width_lp-1:0] gen_inc;
    logic [game_len_width_lp-1:0] snap_inc;

`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
    assign halt = stable_i;
`else
    logic unused_stable;
    assign unused_stable = stable_i;
    assign halt          = 1'b0;
`endif

    assign gen_inc  = gen_q  + game_len_width_lp'(1);
    assign snap_inc = snap_q + game_len_width_lp'(1);

    always_comb begin
        state_d    = state_q;
        gen_d      = gen_q;
        snap_d     = snap_q;
        target_d   = target_q;
        interval_d = interval_q;
        early_d    = early_q;
        ready_o    = 1'b0;
        v_o        = 1'b0;
        update_o   = 1'b0;
        en_o       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_o = en_i;
                if (en_i && v_i) begin
                    update_o   = 1'b1;
                    en_o       = 1'b1;
                    target_d   = frames_i;
                    interval_d = snap_interval_i;
                    gen_d      = '0;
                    snap_d     = '0;
                    early_d    = 1'b0;
                    // A zero-length job hands the loaded board straight back.
                    state_d    = (frames_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                en_o = en_i & ~halt;
                if (en_i) begin
                    if (halt) begin
                        state_d = S_DONE;
                        early_d = 1'b1;
                    end else begin
                        gen_d  = gen_inc;
                        snap_d = snap_inc;
                        // Final generation wins over a coincident snapshot.
                        if (gen_inc == target_q) begin
                            state_d = S_DONE;
                        end else if (interval_q != '0 && snap_inc == interval_q) begin
                            state_d = S_SNAP;
                            snap_d  = '0;
                        end
                    end
                end
            end
            S_SNAP: begin
                v_o = en_i;
                if (en_i && yumi_i) state_d = S_RUN;
            end
            S_DONE: begin
                v_o = en_i;
                if (en_i && yumi_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign last_o  = (state_q == S_DONE);
    assign early_o = (state_q == S_DONE) & early_q;
    assign gen_o   = gen_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            gen_q      <= '0;
            snap_q     <= '0;
            target_q   <= '0;
            interval_q <= '0;
            early_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_q      <= gen_d;
            snap_q     <= snap_d;
            target_q   <= target_d;
            interval_q <= interval_d;
            early_q    <= early_d;
        end
    end

    // Jobs longer than the configured maximum are illegal.
    always_ff @(posedge clk_i) begin
        if (!reset_i && en_i && v_i && state_q == S_IDLE)
            assert (32'(frames_i) <= max_game_length_p);
    end

endmodule

// File: tb/tb_bsg_cgol_ctrl_gen.sv
module tb_bsg_cgol_ctrl_gen;

    localparam int MAXG = 1024;
    localparam int W    = $clog2(MAXG + 1);

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b1;
    logic         en_i = 1'b1;
    logic [W-1:0] frames_i = '0;
    logic [W-1:0] snap_interval_i = '0;
    logic         v_i = 1'b0;
    logic         ready_o;
    logic         stable_i = 1'b0;
    logic         yumi_i = 1'b0;
    logic         v_o;
    logic         last_o;
    logic         early_o;
    logic [W-1:0] gen_o;
    logic         update_o;
    logic         en_o;

    bsg_cgol_ctrl_gen #(.max_game_length_p(MAXG)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .frames_i(frames_i), .snap_interval_i(snap_interval_i),
        .v_i(v_i), .ready_o(ready_o), .stable_i(stable_i),
        .yumi_i(yumi_i), .v_o(v_o), .last_o(last_o), .early_o(early_o),
        .gen_o(gen_o), .update_o(update_o), .en_o(en_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int gen;
        int last;
        int early;
        int steps;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   steps  = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: counts step cycles and pops expectations on each output handshake.
    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (update_o && en_o) steps = 0;
            else if (en_o) steps++;
            if (v_o && yumi_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got gen %0d last %0d, expected none",
                             gen_o, last_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_gen",   int'(gen_o),   e.gen);
                    chk("out_last",  int'(last_o),  e.last);
                    chk("out_early", int'(early_o), e.early);
                    chk("out_steps", steps,         e.steps);
                end
            end
        end
    end

    task automatic push(input int g, input int l, input int e, input int s);
        exp_t x;
        x.gen = g; x.last = l; x.early = e; x.steps = s;
        exp_q.push_back(x);
    endtask

    task automatic start_job(input int frames, input int interval);
        int n = 0;
        while (!ready_o && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("ready_before_job", int'(ready_o), 1);
        frames_i        = W'(frames);
        snap_interval_i = W'(interval);
        v_i             = 1'b1;
        @(negedge clk_i);
        chk("load_update", int'(update_o), 1);
        chk("load_en",     int'(en_o),     1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
    endtask

    task automatic wait_v(input string name);
        int n = 0;
        @(negedge clk_i);
        while (!v_o && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, int'(v_o), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        chk(name, int'(ready_o), 1);
        @(posedge clk_i); #1;
    endtask

    task automatic wait_gen(input int g);
        int n = 0;
        while (int'(gen_o) != g && n < 500) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("reach_gen", int'(gen_o), g);
    endtask

    initial begin
        int lat;

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready",  int'(ready_o),  1);
        chk("rst_v",      int'(v_o),      0);
        chk("rst_last",   int'(last_o),   0);
        chk("rst_early",  int'(early_o),  0);
        chk("rst_gen",    int'(gen_o),    0);
        chk("rst_update", int'(update_o), 0);
        chk("rst_en",     int'(en_o),     0);
        @(posedge clk_i); #1;

        // 5 frames, no snapshots: result 6 cycles after accept.
        yumi_i = 1'b1;
        push(5, 1, 0, 5);
        start_job(5, 0);
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!v_o && lat < 50);
        chk("latency_n5", lat, 6);
        @(negedge clk_i);
        chk("ready_after_yumi", int'(ready_o), 1);
        chk("v_after_yumi",     int'(v_o),     0);
        @(posedge clk_i); #1;

        // 7 frames, snapshot every 3, first snapshot held 4 cycles.
        yumi_i = 1'b0;
        push(3, 0, 0, 3);
        push(6, 0, 0, 6);
        push(7, 1, 0, 7);
        start_job(7, 3);
        wait_v("snap_present");
        for (int i = 0; i < 4; i++) begin
            chk("snap_hold_en",  int'(en_o),   0);
            chk("snap_hold_gen", int'(gen_o),  3);
            chk("snap_hold_v",   int'(v_o),    1);
            chk("snap_hold_last", int'(last_o), 0);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        yumi_i = 1'b1;
        wait_idle("idle_after_snap_job");

        // Zero-length job.
        push(0, 1, 0, 0);
        start_job(0, 0);
        wait_idle("idle_after_zero_job");

        // Stable board after generation 12 of 100.
`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
        push(12, 1, 1, 12);
`else
        push(100, 1, 0, 100);
`endif
        start_job(100, 0);
        wait_gen(12);
        stable_i = 1'b1;
        @(negedge clk_i);
`ifdef BSG_CGOL_CTRL_EARLY_EXIT_EN
        chk("halt_en", int'(en_o), 0);
`else
        chk("halt_en", int'(en_o), 1);
`endif
        wait_idle("idle_after_stable_job");
        stable_i = 1'b0;

        // Global enable dropped for 5 cycles at generation 4 of 10.
        push(10, 1, 0, 10);
        start_job(10, 0);
        wait_gen(4);
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("frz_en",    int'(en_o),    0);
            chk("frz_ready", int'(ready_o), 0);
            chk("frz_v",     int'(v_o),     0);
            chk("frz_gen",   int'(gen_o),   4);
        end
        @(posedge clk_i); #1;
        en_i = 1'b1;
        wait_idle("idle_after_freeze_job");

        // Reset while a snapshot waits, then a normal 2-frame job.
        yumi_i = 1'b0;
        start_job(7, 3);
        wait_v("snap_before_reset");
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_v",     int'(v_o),     0);
        chk("mid_rst_ready", int'(ready_o), 1);
        chk("mid_rst_gen",   int'(gen_o),   0);
        chk("mid_rst_last",  int'(last_o),  0);
        @(posedge clk_i); #1;
        yumi_i = 1'b1;
        push(2, 1, 0, 2);
        start_job(2, 0);
        wait_idle("idle_after_post_reset_job");

        repeat (2) @(posedge clk_i);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
